// File: rtl/temporal_pkg.sv
// Shared types for the temporal encoder: FSM state encoding and the no-spike value convention.
package temporal_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Any channel value at or above the gamma length means "this channel does not fire".
   function automatic logic is_no_spike(input int unsigned value, input int unsigned gamma_len);
      return value >= gamma_len;
   endfunction

endpackage

// File: rtl/temporal_encoder_if.sv
// Valid/ready vector input channel of the temporal encoder.
interface temporal_encoder_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned VAL_W  = 5
);
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_CH*VAL_W-1:0] in_value;

   modport master (output in_valid, output in_value, input  in_ready);
   modport slave  (input  in_valid, input  in_value, output in_ready);
endinterface

// File: rtl/temporal_spike_gen.sv
// One temporal channel: registers the pulse bit for the upcoming gamma position.
module temporal_spike_gen
   import temporal_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   parameter int unsigned PULSE_WIDTH       = 8,
   parameter int unsigned CNT_W             = $clog2(GAMMA_CYCLE_WIDTH),
   parameter int unsigned VAL_W             = CNT_W + 1
) (
   input  logic             aclk,
   input  logic             grst_n,
   input  logic             run,
   input  logic [VAL_W-1:0] value,
   input  logic [CNT_W-1:0] cnt,
   output logic             spike
);

   localparam int unsigned SUM_W = VAL_W + 1;

   logic [SUM_W-1:0] cnt_ext;
   logic [SUM_W-1:0] start_ext;
   logic [SUM_W-1:0] end_ext;
   logic             hit_c;

   // Window [value, value+PULSE_WIDTH); the count never reaches the gamma length, so clipping is implicit.
   always_comb begin
      cnt_ext   = SUM_W'(cnt);
      start_ext = SUM_W'(value);
      end_ext   = start_ext + SUM_W'(PULSE_WIDTH);
      hit_c     = run
                  && !is_no_spike(32'(value), GAMMA_CYCLE_WIDTH)
                  && (start_ext <= cnt_ext)
                  && (cnt_ext < end_ext);
   end

   always_ff @(posedge aclk) begin
      if (!grst_n) begin
         spike <= 1'b0;
      end else begin
         spike <= hit_c;
      end
   end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: stages input vectors and replays them as timed pulses per gamma cycle.
module temporal_encoder
   import temporal_pkg::*;
#(
   parameter int unsigned NUM_CH            = 4,
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   parameter int unsigned PULSE_WIDTH       = 8
) (
   input  logic                                 aclk,
   input  logic                                 grst_n,
   input  logic                                 enable,
   temporal_encoder_if.slave                    in_if,
   output logic                                 gamma_set,
   output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_cnt,
   output logic [NUM_CH-1:0]                    spike_out,
   output logic                                 underrun,
   output logic                                 busy
);

   localparam int unsigned      CNT_W    = $clog2(GAMMA_CYCLE_WIDTH);
   localparam int unsigned      VAL_W    = CNT_W + 1;
   localparam int unsigned      VEC_W    = NUM_CH * VAL_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [VAL_W-1:0] NO_SPIKE = VAL_W'(GAMMA_CYCLE_WIDTH);

   state_e             state;
   state_e             state_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [VEC_W-1:0]   stage;
   logic [VEC_W-1:0]   stage_nxt;
   logic [VEC_W-1:0]   active;
   logic [VEC_W-1:0]   active_nxt;
   logic               stage_full;
   logic               stage_full_nxt;
   logic               in_ready_q;
   logic               underrun_nxt;
   logic               xfer_c;
   logic               run_nxt_c;

   assign xfer_c         = in_if.in_valid && in_ready_q;
   assign in_if.in_ready = in_ready_q;
   assign run_nxt_c      = (state_nxt == RUN);

   // Next state: gamma sequencing plus stage/active hand-off at gamma boundaries.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = gamma_cnt;
      stage_nxt      = stage;
      stage_full_nxt = stage_full;
      active_nxt     = active;
      underrun_nxt   = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable && stage_full) begin
               state_nxt      = RUN;
               active_nxt     = stage;
               stage_full_nxt = 1'b0;
            end
         end
         RUN: begin
            if (gamma_cnt == LAST_CNT) begin
               cnt_nxt = '0;
               if (!enable) begin
                  state_nxt = IDLE;
               end else if (stage_full) begin
                  active_nxt     = stage;
                  stage_full_nxt = 1'b0;
               end else begin
                  active_nxt   = {NUM_CH{NO_SPIKE}};
                  underrun_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = gamma_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A vector taken on a wrap edge lands in the stage; it never bypasses into active.
      if (xfer_c) begin
         stage_nxt      = in_if.in_value;
         stage_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!grst_n) begin
         state      <= IDLE;
         gamma_cnt  <= '0;
         stage      <= '0;
         stage_full <= 1'b0;
         active     <= {NUM_CH{NO_SPIKE}};
         in_ready_q <= 1'b1;
         gamma_set  <= 1'b0;
         underrun   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         gamma_cnt  <= cnt_nxt;
         stage      <= stage_nxt;
         stage_full <= stage_full_nxt;
         active     <= active_nxt;
         in_ready_q <= !stage_full_nxt;
         gamma_set  <= run_nxt_c && (cnt_nxt == '0);
         underrun   <= underrun_nxt;
         busy       <= run_nxt_c;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      temporal_spike_gen #(
         .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
         .PULSE_WIDTH       (PULSE_WIDTH),
         .CNT_W             (CNT_W),
         .VAL_W             (VAL_W)
      ) u_spike_gen (
         .aclk   (aclk),
         .grst_n (grst_n),
         .run    (run_nxt_c),
         .value  (active_nxt[i*VAL_W +: VAL_W]),
         .cnt    (cnt_nxt),
         .spike  (spike_out[i])
      );
   end

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder: vector table, scoreboard queue and corner-case sequences.
module tb_temporal_encoder;

   typedef struct packed {
      logic [3:0][4:0]  val;
      logic [3:0][15:0] mask;   // bit k of mask[i] = expected spike_out[i] at gamma_cnt k
   } vec_t;

   typedef struct {
      vec_t v;
      int   acc;                // edge number at which the DUT accepts the vector
   } sb_t;

   logic       aclk = 1'b0;
   logic       grst_n;
   logic       enable;
   logic       gamma_set;
   logic [3:0] gamma_cnt;
   logic [3:0] spike_out;
   logic       underrun;
   logic       busy;

   int   checks   = 0;
   int   failures = 0;
   int   edge_n   = 0;
   bit   mon_en   = 1'b0;
   vec_t tbl[4];
   sb_t  sb[$];

   temporal_encoder_if #(.NUM_CH(4), .VAL_W(5)) in_if ();

   temporal_encoder #(
      .NUM_CH            (4),
      .GAMMA_CYCLE_WIDTH (16),
      .PULSE_WIDTH       (8)
   ) dut (
      .aclk      (aclk),
      .grst_n    (grst_n),
      .enable    (enable),
      .in_if     (in_if),
      .gamma_set (gamma_set),
      .gamma_cnt (gamma_cnt),
      .spike_out (spike_out),
      .underrun  (underrun),
      .busy      (busy)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Offer a vector from a negedge; it is accepted on the next posedge if in_ready is high.
   task automatic send(input vec_t t);
      bit done;
      done = 1'b0;
      @(negedge aclk);
      in_if.in_valid = 1'b1;
      in_if.in_value = t.val;
      for (int n = 0; n < 100 && !done; n++) begin
         if (n > 0) @(negedge aclk);
         if (in_if.in_ready === 1'b1) begin
            sb.push_back('{v: t, acc: edge_n + 1});
            done = 1'b1;
         end
      end
      if (done) begin
         @(posedge aclk);
         #1 in_if.in_valid = 1'b0;
      end else begin
         chk("send_timeout", 32'(0), 32'(1));
         in_if.in_valid = 1'b0;
      end
   endtask

   // Scoreboard monitor: pops the staged vector at each gamma start and checks every cycle.
   int         k, prev_k;
   bit         prev_busy, cur_ok, stage_exp;
   sb_t        cur;
   logic [3:0] em;

   always @(negedge aclk) begin
      if (mon_en) begin
         if (busy === 1'b1) begin
            k = prev_busy ? (prev_k + 1) % 16 : 0;
            if (k == 0) begin
               if (sb.size() > 0 && sb[0].acc < edge_n) begin
                  cur    = sb.pop_front();
                  cur_ok = 1'b1;
               end else begin
                  cur_ok = 1'b0;
               end
            end
            for (int i = 0; i < 4; i++) em[i] = cur_ok ? cur.v.mask[i][k] : 1'b0;
            chk("gamma_cnt", 32'(gamma_cnt), k);
            chk("gamma_set", 32'(gamma_set), (k == 0) ? 1 : 0);
            chk("underrun", 32'(underrun), (k == 0 && !cur_ok) ? 1 : 0);
            chk("spike_out", 32'(spike_out), 32'(em));
         end else begin
            k = 0;
            chk("idle_gamma_set", 32'(gamma_set), 0);
            chk("idle_underrun", 32'(underrun), 0);
            chk("idle_spike_out", 32'(spike_out), 0);
            chk("idle_gamma_cnt", 32'(gamma_cnt), 0);
            if (prev_busy && grst_n) chk("early_stop_cnt", prev_k, 15);
         end
         stage_exp = sb.size() > 0 && sb[0].acc <= edge_n;
         chk("in_ready", 32'(in_if.in_ready), stage_exp ? 0 : 1);
         prev_busy = (busy === 1'b1);
         prev_k    = k;
      end
   end

   initial begin
      bit found;

      tbl[0].val  = {5'd16, 5'd10, 5'd3, 5'd0};
      tbl[0].mask = {16'h0000, 16'hFC00, 16'h07F8, 16'h00FF};
      tbl[1].val  = {5'd3, 5'd2, 5'd1, 5'd15};
      tbl[1].mask = {16'h07F8, 16'h03FC, 16'h01FE, 16'h8000};
      tbl[2].val  = {5'd7, 5'd9, 5'd31, 5'd8};
      tbl[2].mask = {16'h7F80, 16'hFE00, 16'h0000, 16'hFF00};
      tbl[3].val  = {5'd0, 5'd12, 5'd5, 5'd17};
      tbl[3].mask = {16'h00FF, 16'hF000, 16'h1FE0, 16'h0000};

      grst_n         = 1'b0;
      enable         = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_value = '0;

      // Reset state
      repeat (3) @(negedge aclk);
      chk("rst_in_ready", 32'(in_if.in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gamma_set", 32'(gamma_set), 0);
      chk("rst_spike_out", 32'(spike_out), 0);
      chk("rst_underrun", 32'(underrun), 0);
      chk("rst_gamma_cnt", 32'(gamma_cnt), 0);
      mon_en = 1'b1;
      #1 grst_n = 1'b1;
      enable = 1'b1;

      // Start latency, then back-to-back table vectors
      send(tbl[0]);
      @(negedge aclk);
      chk("latency_still_idle", 32'(busy), 0);
      @(negedge aclk);
      chk("latency_busy", 32'(busy), 1);
      chk("latency_gamma_set", 32'(gamma_set), 1);
      chk("latency_v0_spike", 32'(spike_out[0]), 1);
      for (int i = 1; i < 4; i++) send(tbl[i]);

      // Underrun after the last vector
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge aclk);
         if (underrun === 1'b1) found = 1'b1;
      end
      chk("underrun_seen", 32'(found), 1);
      chk("underrun_gamma_set", 32'(gamma_set), 1);
      chk("underrun_spikes", 32'(spike_out), 0);

      // enable dropped at cnt 5: gamma completes, staged vector retained
      send(tbl[1]);
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(negedge aclk);
         if (gamma_set === 1'b1) found = 1'b1;
      end
      chk("drop_gamma_start", 32'(found), 1);
      for (int n = 0; n < 20 && gamma_cnt != 4'd5; n++) @(negedge aclk);
      chk("drop_at_cnt5", 32'(gamma_cnt), 5);
      #1 enable = 1'b0;
      send(tbl[2]);
      found = 1'b0;
      for (int n = 0; n < 40 && busy === 1'b1; n++) begin
         @(negedge aclk);
         if (busy === 1'b1 && gamma_cnt == 4'd15) found = 1'b1;
      end
      chk("drop_reached_cnt15", 32'(found), 1);
      chk("drop_idle", 32'(busy), 0);
      repeat (4) begin
         @(negedge aclk);
         chk("drop_stays_idle", 32'(busy), 0);
         chk("drop_stage_kept", 32'(in_if.in_ready), 0);
      end
      #1 enable = 1'b1;
      @(negedge aclk);
      chk("resume_busy", 32'(busy), 1);
      chk("resume_gamma_set", 32'(gamma_set), 1);

      // Synchronous reset at cnt 7 with ch0 mid-pulse and a vector staged
      send(tbl[0]);
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(negedge aclk);
         if (gamma_set === 1'b1) found = 1'b1;
      end
      chk("rst_gamma_start", 32'(found), 1);
      send(tbl[3]);
      for (int n = 0; n < 20 && gamma_cnt != 4'd7; n++) @(negedge aclk);
      chk("pre_rst_cnt7", 32'(gamma_cnt), 7);
      chk("pre_rst_pulse", 32'(spike_out[0]), 1);
      #1 grst_n = 1'b0;
      sb.delete();
      @(negedge aclk);
      chk("mid_rst_spike_out", 32'(spike_out), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_in_ready", 32'(in_if.in_ready), 1);
      chk("mid_rst_gamma_cnt", 32'(gamma_cnt), 0);
      #1 grst_n = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         chk("post_rst_stage_empty", 32'(busy), 0);
      end

      enable = 1'b0;
      repeat (2) @(negedge aclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Binary-to-temporal encoder for the race-logic datapath: accepts a vector of NUM_CH binary values through a valid/ready handshake and replays each as a pulse of PULSE_WIDTH cycles at a time offset within a repeating gamma cycle of GAMMA_CYCLE_WIDTH cycles. It drives the inputs of the pulse-width temporal primitives (less_than and peers), and supplies the gamma-start `gamma_set` strobe that re-arms their latches. A one-entry staging buffer lets the next vector load while the current gamma cycle plays out.

## Interface
- NUM_CH, 4: number of independent temporal channels.
- GAMMA_CYCLE_WIDTH, 16: gamma cycle length in aclk cycles; must be at least 2.
- PULSE_WIDTH, 8: spike pulse length in cycles; 1 <= PULSE_WIDTH < GAMMA_CYCLE_WIDTH.
- VAL_W (derived localparam): $clog2(GAMMA_CYCLE_WIDTH)+1.
- aclk  in  1  clock; all logic on posedge.
- grst_n  in  1  reset, synchronous, active-low.
- enable  in  1  run request; sampled at gamma boundaries and in IDLE.
- in_valid  in  1  input vector valid.
- in_ready  out  1  staging buffer empty.
- in_value  in  NUM_CH*VAL_W  channel i in bits [i*VAL_W +: VAL_W]; value >= GAMMA_CYCLE_WIDTH means no spike.
- gamma_set  out  1  high for exactly the cycle with gamma_cnt==0 while RUN.
- gamma_cnt  out  $clog2(GAMMA_CYCLE_WIDTH)  position within the current gamma cycle.
- spike_out  out  NUM_CH  temporal pulses.
- underrun  out  1  one-cycle flag: a gamma cycle started with no staged vector.
- busy  out  1  state==RUN.

## Operation
- FSM states: IDLE, RUN. Reset: IDLE, gamma_cnt=0, stage empty, active values = no-spike, all outputs 0 except in_ready=1.
- Handshake: transfer on posedge with in_valid && in_ready; vector written to stage; in_ready falls the next cycle. in_value held stable only while in_valid && !in_ready.
- IDLE -> RUN on posedge when enable && stage full: active <= stage, stage emptied, gamma_cnt <= 0.
- RUN: gamma_cnt increments each cycle, wraps GAMMA_CYCLE_WIDTH-1 -> 0. At the wrap edge:
  - enable && stage full: active <= stage, stage emptied, stay RUN.
  - enable && stage empty: active <= all no-spike, underrun=1 for the new cycle 0, stay RUN.
  - !enable: go IDLE, gamma_cnt=0, stage retained.
- enable deassertion mid-gamma never truncates the current gamma cycle.
- spike_out[i] in the cycle where gamma_cnt==k (RUN only): 1 iff v_i <= k < v_i+PULSE_WIDTH. The sum uses VAL_W+1 bits (no overflow). Pulses are clipped at gamma end; they never carry into the next gamma cycle.
- v_i >= GAMMA_CYCLE_WIDTH: spike_out[i] stays 0 for the whole gamma cycle.
- Handshake on the wrap edge with stage empty: the vector goes to stage, not active. There is no bypass, and underrun still fires.
- Synchronous reset mid-operation: next cycle equals the reset state. In-flight and staged data are discarded.

## Timing
- All outputs are registered. in_ready, busy, gamma_set, underrun and spike_out change only on posedge aclk.
- Latency: handshake at edge E in IDLE with enable=1 -> RUN after edge E+1; gamma_set and cycle-0 spikes visible in the cycle after E+1.
- Back-to-back vectors give gamma_set exactly every GAMMA_CYCLE_WIDTH cycles with no idle gap.
- gamma_set and a v_i=0 spike assert in the same cycle.

## Structure
- Package temporal_pkg: state enum typedef (IDLE, RUN) and the no-spike encoding convention (value >= GAMMA_CYCLE_WIDTH). Width localparams stay in the module because they depend on its parameters.
- Sub-module temporal_spike_gen, instantiated NUM_CH times. It takes an active value and gamma_cnt and produces one registered spike bit, including clipping and the no-spike decode.
- The top level holds the FSM, gamma counter, staging and active registers, and the handshake.

## Test plan
- Reset: hold grst_n=0 for 3 cycles -> in_ready=1; busy, gamma_set, spike_out and underrun are all 0; gamma_cnt=0.
- Basic encode with defaults: values {0,3,10,16}, enable=1.
  - ch0 high at cnt 0-7; ch1 high at cnt 3-10.
  - ch2 high at cnt 10-15 (clipped to 6 cycles); ch3 never high.
  - gamma_set high at cnt 0 only.
- Back-to-back: second vector {15,1,2,3} offered during gamma 1.
  - in_ready stays 0 from its acceptance until the wrap edge.
  - Gamma 2 plays the second vector with no gap; ch0 is high only at cnt 15.
- Underrun: a single vector with enable held -> gamma 2 shows underrun=1 at cnt 0, all spike_out 0, gamma_set still asserted.
- enable dropped at cnt 5 -> gamma completes through cnt 15, then IDLE (busy=0, no further gamma_set); a staged vector is retained and plays after enable returns.
- grst_n=0 at cnt 7 with ch0 mid-pulse -> the next cycle has spike_out=0, IDLE, stage empty, in_ready=1.
